// File: rtl/sim_video_gen_if.sv
// Pixel stream bundle for sim_video_gen: data plus start-of-frame/end markers on valid/ready.
interface sim_video_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] vtdata;
  logic              vtvalid;
  logic              vtuser;
  logic              vtlast;
  logic              vtready;

  modport master (output vtdata, output vtvalid, output vtuser, output vtlast, input vtready);
  modport slave  (input vtdata, input vtvalid, input vtuser, input vtlast, output vtready);
endinterface

// File: rtl/sim_video_gen.sv
// Simulation video source: H_ACTIVE x V_ACTIVE frames with programmable beat/line gaps.
// Define SIM_VIDEO_RANDGAP_EN to draw each beat gap from a 16-bit LFSR in 0..BEAT_GAP.
module sim_video_gen #(
  parameter int H_ACTIVE  = 16,
  parameter int V_ACTIVE  = 10,
  parameter int DATA_W    = 8,
  parameter int BEAT_GAP  = 3,
  parameter int LINE_GAP  = 0,
  parameter int LAST_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [7:0]     frames,
  input  logic           stop,
  output logic           busy,
  output logic           frame_done,
  sim_video_gen_if.master vt
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int GW = $clog2(BEAT_GAP + LINE_GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [7:0]        f_q, f_d;
  logic [7:0]        rem_q, rem_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [1:0]        mode_q, mode_d;
  logic [7:0]        frames_q, frames_d;
  logic              stop_q, stop_d;

  logic              hs_s, x_end_s, y_end_s, frame_end_s, halt_s, active_s;
  logic [GW-1:0]     beat_gap_s, gap_len_s;
  logic [DATA_W-1:0] x_ext_s, y_ext_s, f_ext_s, pix_s;

`ifdef SIM_VIDEO_RANDGAP_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign beat_gap_s = GW'(32'(lfsr_q[7:0]) % (BEAT_GAP + 1));
`else
  assign beat_gap_s = GW'(BEAT_GAP);
`endif

  assign active_s    = (state_q == S_ACTIVE);
  assign x_end_s     = (x_q == XW'(H_ACTIVE - 1));
  assign y_end_s     = (y_q == YW'(V_ACTIVE - 1));
  assign hs_s        = active_s && vt.vtready;
  assign frame_end_s = hs_s && x_end_s && y_end_s;
  // A stop raised in the frame-end handshake cycle still ends the run here.
  assign halt_s      = ((frames_q != 8'd0) && (rem_q == 8'd1)) || stop_q || stop;
  assign gap_len_s   = beat_gap_s + (x_end_s ? GW'(LINE_GAP) : {GW{1'b0}});

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= {XW{1'b0}};
      y_q      <= {YW{1'b0}};
      f_q      <= 8'd0;
      rem_q    <= 8'd0;
      gap_q    <= {GW{1'b0}};
      mode_q   <= 2'd0;
      frames_q <= 8'd0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      f_q      <= f_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      frames_q <= frames_d;
      stop_q   <= stop_d;
    end
  end

  // Next-state and counter advance
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    f_d      = f_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    frames_d = frames_q;
    stop_d   = stop_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ACTIVE;
          mode_d   = mode;
          frames_d = frames;
          rem_d    = frames;
          x_d      = {XW{1'b0}};
          y_d      = {YW{1'b0}};
          f_d      = 8'd0;
          gap_d    = {GW{1'b0}};
          stop_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        stop_d = stop_q | stop;
        if (hs_s) begin
          x_d = x_end_s ? {XW{1'b0}} : x_q + 1'b1;
          if (x_end_s) begin
            y_d = y_end_s ? {YW{1'b0}} : y_q + 1'b1;
          end else begin
            y_d = y_q;
          end
          if (frame_end_s) begin
            f_d   = f_q + 8'd1;
            rem_d = (frames_q != 8'd0) ? rem_q - 8'd1 : rem_q;
          end else begin
            f_d   = f_q;
          end
          if (frame_end_s && halt_s) begin
            state_d = S_IDLE;
          end else if (gap_len_s != {GW{1'b0}}) begin
            state_d = S_GAP;
            gap_d   = gap_len_s - 1'b1;
          end else begin
            state_d = S_ACTIVE;
          end
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_GAP: begin
        stop_d = stop_q | stop;
        if (gap_q == {GW{1'b0}}) begin
          state_d = S_ACTIVE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_ext_s = DATA_W'(x_q);
  assign y_ext_s = DATA_W'(y_q);
  assign f_ext_s = DATA_W'(f_q);

  // Stream outputs, forced quiet whenever no beat is offered
  always_comb begin
    case (mode_q)
      2'd0:    pix_s = {y_ext_s[DATA_W/2-1:0], x_ext_s[DATA_W/2-1:0]};
      2'd1:    pix_s = x_ext_s;
      2'd2:    pix_s = {DATA_W{x_q[0] ^ y_q[0]}};
      2'd3:    pix_s = f_ext_s;
      default: pix_s = {DATA_W{1'b0}};
    endcase
    vt.vtvalid = active_s;
    vt.vtdata  = active_s ? pix_s : {DATA_W{1'b0}};
    vt.vtuser  = active_s && (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
    vt.vtlast  = active_s && x_end_s && ((LAST_MODE != 0) || y_end_s);
    busy       = (state_q != S_IDLE);
    frame_done = frame_end_s;
  end
endmodule
